// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: divider FSM states, the
// divide-by-zero quotient constant and counter sizing helper.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } div_state_t;

  localparam int unsigned MDU_MAX_WIDTH = 64;

  // Divide-by-zero quotient is all ones; consumers slice to their width.
  localparam logic [MDU_MAX_WIDTH-1:0] DIV_DBZ_Q = '1;

  function automatic int unsigned div_cnt_w(input int unsigned width,
                                            input int unsigned step_bits);
    return $clog2(width / step_bits + 1);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and keep the subtraction only when it does not borrow.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] window;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  always_comb begin
    window  = {rem_in, quo_in[WIDTH-1]};
    diff    = window - {2'b00, divisor};
    borrow  = diff[WIDTH+1];
    rem_out = borrow ? window[WIDTH:0] : diff[WIDTH:0];
    quo_out = {quo_in[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/mdu_div_iter.sv
// Iterative restoring divider, STEP_BITS quotient bits per cycle, signed or unsigned.
// Optional DIV_EARLY_TERM_EN: finish in two cycles when |b| > |a| (b != 0).
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dbz
);

  localparam int unsigned N      = WIDTH / STEP_BITS;
  localparam int unsigned CNT_W  = div_cnt_w(WIDTH, STEP_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  div_state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] a_raw;
  logic             neg_q;
  logic             neg_r;
  logic             is_dbz;

  logic             a_neg, b_neg, b_zero, accept, early_ok;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] q_fix, r_fix;

  logic [WIDTH:0]   rem_c [STEP_BITS+1];
  logic [WIDTH-1:0] quo_c [STEP_BITS+1];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    a_neg  = in_signed & in_a[WIDTH-1];
    b_neg  = in_signed & in_b[WIDTH-1];
    a_abs  = a_neg ? (~in_a + 1'b1) : in_a;
    b_abs  = b_neg ? (~in_b + 1'b1) : in_b;
    b_zero = (in_b == '0);
    accept = in_valid & in_ready & ~flush;
`ifdef DIV_EARLY_TERM_EN
    early_ok = ~b_zero & (b_abs > a_abs);
`else
    early_ok = 1'b0;
`endif
  end

  assign rem_c[0] = rem;
  assign quo_c[0] = quo;

  for (genvar i = 0; i < STEP_BITS; i++) begin : g_step
    mdu_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_c[i]),
      .quo_in  (quo_c[i]),
      .divisor (dvs),
      .rem_out (rem_c[i+1]),
      .quo_out (quo_c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: if (in_valid) state_nx = early_ok ? FIX : ITER;
        ITER: if (cnt == CNT_LAST) state_nx = FIX;
        FIX:  state_nx = DONE;
        DONE: if (out_ack) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    q_fix = neg_q ? (~quo + 1'b1) : quo;
    r_fix = neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
    if (is_dbz) begin
      q_fix = DIV_DBZ_Q[WIDTH-1:0];
      r_fix = a_raw;
    end
  end

  // Dividend magnitude sits in quo and shifts out MSB-first as quotient bits enter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      a_raw   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      is_dbz  <= 1'b0;
      out_q   <= '0;
      out_r   <= '0;
      out_dbz <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_raw  <= in_a;
            dvs    <= b_abs;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            is_dbz <= b_zero;
            cnt    <= '0;
            if (early_ok) begin
              rem <= {1'b0, a_abs};
              quo <= '0;
            end else begin
              rem <= '0;
              quo <= a_abs;
            end
          end
        end
        ITER: begin
          if (!flush) begin
            rem <= rem_c[STEP_BITS];
            quo <= quo_c[STEP_BITS];
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!flush) begin
            out_q   <= q_fix;
            out_r   <= r_fix;
            out_dbz <= is_dbz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
